// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: round-robin bridge of CPU fetch and data ports onto one req/ack memory port.
// Define BRIDGE_IBUF_EN to add a one-entry fetch buffer in front of the memory port.

module cpu_mem_bridge #(
    parameter int WORD        = 64,
    parameter int INST_SIZE   = 32,
    parameter int ADDR_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic [INST_SIZE-1:0] i_rdata,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [WORD-1:0]      d_wdata,
    output logic [WORD-1:0]      d_rdata,
    output logic                 d_ack,
    output logic                 stall,
    output logic                 m_req,
    output logic                 m_we,
    output logic                 m_sel,
    output logic [ADDR_W-1:0]    m_addr,
    output logic [WORD-1:0]      m_wdata,
    input  logic [WORD-1:0]      m_rdata,
    input  logic                 m_ack,
    output logic                 err
);

    localparam int OFF    = $clog2(WORD / 8);
    localparam int ILOG   = $clog2(INST_SIZE / 8);
    localparam int NLANES = WORD / INST_SIZE;
    localparam int LW     = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int TW     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]           r_state;
    logic                 r_prefData;
    logic                 r_sel;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [WORD-1:0]      r_wdata;
    logic [LW-1:0]        r_lane;
    logic [INST_SIZE-1:0] r_iRdata;
    logic [WORD-1:0]      r_dRdata;
    logic [TW-1:0]        r_timeCnt;

    logic [ADDR_W-1:0]    w_fetchAddr;
    logic [LW-1:0]        w_fetchLane;
    logic [OFF-1:0]       w_unusedAddrLow;
    logic                 w_anyReq;
    logic                 w_grantData;
    logic                 w_timeout;

`ifdef BRIDGE_IBUF_EN
    logic                 r_bufValid;
    logic [ADDR_W-1:0]    r_bufTag;
    logic [WORD-1:0]      r_bufData;
    logic                 w_hit;

    assign w_hit = r_bufValid && (r_bufTag == w_fetchAddr);
`endif

    function automatic logic [INST_SIZE-1:0] laneOf(input logic [WORD-1:0] word,
                                                    input logic [LW-1:0] lane);
        return word[int'(lane) * INST_SIZE +: INST_SIZE];
    endfunction

    assign w_fetchAddr     = {i_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
    assign w_unusedAddrLow = i_addr[OFF-1:0];

    generate
        if (NLANES > 1) begin : g_lane
            assign w_fetchLane = i_addr[OFF-1:ILOG];
        end else begin : g_noLane
            assign w_fetchLane = '0;
        end
    endgenerate

    // Priority pointer only moves on contested grants, so a lone requester never steals the turn.
    assign w_anyReq    = i_req | d_req;
    assign w_grantData = d_req & (~i_req | r_prefData);
    assign w_timeout   = (TIMEOUT_CYC != 0) && (r_timeCnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_prefData <= 1'b1;
            r_sel      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lane     <= '0;
            r_iRdata   <= '0;
            r_dRdata   <= '0;
            r_timeCnt  <= '0;
`ifdef BRIDGE_IBUF_EN
            r_bufValid <= 1'b0;
            r_bufTag   <= '0;
            r_bufData  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_timeCnt <= '0;
                        if (i_req && d_req) begin
                            r_prefData <= ~w_grantData;
                        end
                        if (w_grantData) begin
                            r_sel   <= 1'b1;
                            r_we    <= d_we;
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                            r_state <= ST_BUSY;
`ifdef BRIDGE_IBUF_EN
                            if (d_we && (d_addr == r_bufTag)) begin
                                r_bufValid <= 1'b0;
                            end
`endif
                        end else begin
                            r_sel   <= 1'b0;
                            r_we    <= 1'b0;
                            r_addr  <= w_fetchAddr;
                            r_wdata <= '0;
                            r_lane  <= w_fetchLane;
`ifdef BRIDGE_IBUF_EN
                            if (w_hit) begin
                                r_iRdata <= laneOf(r_bufData, w_fetchLane);
                                r_state  <= ST_RESP;
                            end else begin
                                r_state  <= ST_BUSY;
                            end
`else
                            r_state <= ST_BUSY;
`endif
                        end
                    end
                end
                ST_BUSY: begin
                    if (m_ack) begin
                        r_state <= ST_RESP;
                        if (r_sel) begin
                            if (!r_we) begin
                                r_dRdata <= m_rdata;
                            end
                        end else begin
                            r_iRdata <= laneOf(m_rdata, r_lane);
`ifdef BRIDGE_IBUF_EN
                            r_bufValid <= 1'b1;
                            r_bufTag   <= r_addr;
                            r_bufData  <= m_rdata;
`endif
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_timeCnt <= r_timeCnt + 1'b1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_ERR;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from state so an async reset drops m_req at once.
    assign m_req   = (r_state == ST_BUSY);
    assign m_we    = r_we;
    assign m_sel   = r_sel;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign i_ack   = (r_state == ST_RESP) && !r_sel;
    assign d_ack   = (r_state == ST_RESP) && r_sel;
    assign i_rdata = r_iRdata;
    assign d_rdata = r_dRdata;
    assign err     = (r_state == ST_ERR);
    assign stall   = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: scoreboarded memory requests and CPU responses.
// Build with BRIDGE_IBUF_EN defined to exercise the fetch-buffer expectations.

module tb_cpu_mem_bridge;

   localparam int TO = 8;
`ifdef BRIDGE_IBUF_EN
   localparam bit IBUF_ON = 1'b1;
`else
   localparam bit IBUF_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we;
   logic [63:0] i_addr, d_addr, d_wdata;
   logic [31:0] i_rdata;
   logic [63:0] d_rdata;
   logic        i_ack, d_ack, stall, m_req, m_we, m_sel, err;
   logic [63:0] m_addr, m_wdata, m_rdata;
   logic        m_ack;

   typedef struct packed {
      logic        sel;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } memExp_t;

   typedef struct packed {
      logic        isData;
      logic [63:0] data;
   } respExp_t;

   memExp_t     memQ[$];
   respExp_t    respQ[$];
   logic [63:0] memArr[logic [63:0]];
   logic [63:0] refMem[logic [63:0]];

   int          vectorCount = 0;
   int          missCount   = 0;
   int          memDelay    = 0;
   bit          memAckEn    = 1'b1;
   int          busyCnt     = 0;
   logic [63:0] lastLoad    = 64'h0;
   logic [63:0] lastFetch   = 64'h0;
   bit          tbBufValid  = 1'b0;
   logic [63:0] tbBufTag    = 64'h0;

   always #5 clk = ~clk;

   cpu_mem_bridge #(
      .WORD(64), .INST_SIZE(32), .ADDR_W(64), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .stall(stall),
      .m_req(m_req), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
   );

   // Counts one comparison and reports it when observed and expected disagree.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [63:0] initWord(input logic [63:0] a);
      return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
   endfunction

   function automatic logic [63:0] refRead(input logic [63:0] a);
      if (refMem.exists(a)) return refMem[a];
      return initWord(a);
   endfunction

   function automatic logic [63:0] memRead(input logic [63:0] a);
      if (memArr.exists(a)) return memArr[a];
      return initWord(a);
   endfunction

   function automatic bit predictHit(input logic [63:0] a);
      return IBUF_ON && tbBufValid && (tbBufTag == a);
   endfunction

   // Memory responder: checks each new request against the scoreboard, then acks after memDelay.
   always @(negedge clk) begin
      memExp_t e;
      if (m_req && !m_ack) begin
         if (busyCnt == 0) begin
            if (memQ.size() == 0) begin
               checkOutput("unexpectedMreq", {63'b0, m_req}, 64'h0);
            end else begin
               e = memQ.pop_front();
               checkOutput("mSel", {63'b0, m_sel}, {63'b0, e.sel});
               checkOutput("mWe", {63'b0, m_we}, {63'b0, e.we});
               checkOutput("mAddr", m_addr, e.addr);
               if (e.we) checkOutput("mWdata", m_wdata, e.wdata);
            end
         end
         if (memAckEn && busyCnt == memDelay) begin
            if (m_we) memArr[m_addr] = m_wdata;
            m_rdata = memRead(m_addr);
            m_ack   = 1'b1;
         end
         busyCnt++;
      end else begin
         m_ack = 1'b0;
         if (!m_req) busyCnt = 0;
      end
   end

   // Response monitor: every CPU-side ack pops and checks the oldest expected response.
   always @(negedge clk) begin
      respExp_t r;
      if (i_ack || d_ack) begin
         checkOutput("ackOnehot", {63'b0, i_ack & d_ack}, 64'h0);
         if (respQ.size() == 0) begin
            checkOutput("unexpectedAck", {63'b0, i_ack | d_ack}, 64'h0);
         end else begin
            r = respQ.pop_front();
            checkOutput("ackSel", {63'b0, d_ack}, {63'b0, r.isData});
            if (r.isData) checkOutput("dRdata", d_rdata, r.data);
            else          checkOutput("iRdata", {32'b0, i_rdata}, r.data);
         end
      end
   end

   task automatic resetModels();
      lastLoad   = 64'h0;
      tbBufValid = 1'b0;
   endtask

   // Waits for the selected ack, checking stall on the way; returns cycles since request.
   task automatic waitAck(input bit isData, output int lat);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (isData ? d_ack : i_ack) begin
            checkOutput("stallAtAck", {63'b0, stall}, 64'h0);
            break;
         end
         checkOutput("stallWait", {63'b0, stall}, 64'h1);
      end
   endtask

   task automatic applyFetch(input logic [63:0] addr, input int delay);
      logic [63:0] al, w, expData;
      bit          hit;
      int          lat;
      al      = {addr[63:3], 3'b0};
      hit     = predictHit(al);
      w       = refRead(al);
      expData = addr[2] ? {32'b0, w[63:32]} : {32'b0, w[31:0]};
      memDelay = delay;
      if (!hit) begin
         memQ.push_back('{sel: 1'b0, we: 1'b0, addr: al, wdata: 64'h0});
         tbBufValid = 1'b1;
         tbBufTag   = al;
      end
      respQ.push_back('{isData: 1'b0, data: expData});
      lastFetch = expData;
      @(posedge clk); #1;
      i_req  = 1'b1;
      i_addr = addr;
      waitAck(1'b0, lat);
      checkOutput("fetchLat", lat, hit ? 64'd2 : 64'(3 + delay));
      @(posedge clk); #1;
      i_req = 1'b0;
      @(negedge clk);
      checkOutput("stallIdle", {63'b0, stall}, 64'h0);
   endtask

   task automatic applyData(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                            input int delay);
      int lat;
      memDelay = delay;
      memQ.push_back('{sel: 1'b1, we: we, addr: addr, wdata: wdata});
      if (we) begin
         refMem[addr] = wdata;
         if (addr == tbBufTag) tbBufValid = 1'b0;
      end else begin
         lastLoad = refRead(addr);
      end
      respQ.push_back('{isData: 1'b1, data: lastLoad});
      @(posedge clk); #1;
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
      waitAck(1'b1, lat);
      checkOutput("dataLat", lat, 64'(3 + delay));
      @(posedge clk); #1;
      d_req = 1'b0;
      @(negedge clk);
      checkOutput("stallIdle", {63'b0, stall}, 64'h0);
   endtask

   // Simultaneous fetch + load; dataFirst states which one must win arbitration.
   task automatic applyPair(input logic [63:0] iaddr, input logic [63:0] daddr, input bit dataFirst);
      logic [63:0] al, w;
      respExp_t    fr, dr;
      bit          hit, iDone, dDone;
      int          n;
      al  = {iaddr[63:3], 3'b0};
      hit = predictHit(al);
      w   = refRead(al);
      fr  = '{isData: 1'b0, data: iaddr[2] ? {32'b0, w[63:32]} : {32'b0, w[31:0]}};
      lastLoad = refRead(daddr);
      dr  = '{isData: 1'b1, data: lastLoad};
      lastFetch = fr.data;
      memDelay = 1;
      if (dataFirst) begin
         memQ.push_back('{sel: 1'b1, we: 1'b0, addr: daddr, wdata: 64'h0});
         if (!hit) memQ.push_back('{sel: 1'b0, we: 1'b0, addr: al, wdata: 64'h0});
         respQ.push_back(dr);
         respQ.push_back(fr);
      end else begin
         if (!hit) memQ.push_back('{sel: 1'b0, we: 1'b0, addr: al, wdata: 64'h0});
         memQ.push_back('{sel: 1'b1, we: 1'b0, addr: daddr, wdata: 64'h0});
         respQ.push_back(fr);
         respQ.push_back(dr);
      end
      if (!hit) begin
         tbBufValid = 1'b1;
         tbBufTag   = al;
      end
      @(posedge clk); #1;
      i_req  = 1'b1;
      i_addr = iaddr;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = daddr;
      iDone  = 1'b0;
      dDone  = 1'b0;
      n      = 0;
      while (!(iDone && dDone) && n < 60) begin
         @(negedge clk);
         n++;
         if (i_ack) iDone = 1'b1;
         if (d_ack) dDone = 1'b1;
         @(posedge clk); #1;
         if (iDone) i_req = 1'b0;
         if (dDone) d_req = 1'b0;
      end
      checkOutput("pairDone", {63'b0, iDone && dDone}, 64'h1);
   endtask

   initial begin
      int n;
      rst     = 1'b1;
      i_req   = 1'b0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      i_addr  = 64'h0;
      d_addr  = 64'h0;
      d_wdata = 64'h0;
      m_ack   = 1'b0;
      m_rdata = 64'h0;
      memArr[64'h10] = 64'h1111_2222_3333_4444;
      refMem[64'h10] = 64'h1111_2222_3333_4444;

      repeat (2) @(negedge clk);
      checkOutput("rstMreq", {63'b0, m_req}, 64'h0);
      checkOutput("rstErr", {63'b0, err}, 64'h0);
      checkOutput("rstAcks", {62'b0, i_ack, d_ack}, 64'h0);
      checkOutput("rstMaddr", m_addr, 64'h0);
      checkOutput("rstIrdata", {32'b0, i_rdata}, 64'h0);
      checkOutput("rstDrdata", d_rdata, 64'h0);
      #2 rst = 1'b0;

      $display("[TB] arbitration after reset");
      applyPair(64'h40, 64'h80, 1'b1);
      applyPair(64'h44, 64'h88, 1'b0);

      $display("[TB] fetch lane select");
      applyFetch(64'h14, 0);
      applyFetch(64'h10, 0);

      $display("[TB] delayed store and readback");
      applyData(1'b1, 64'h100, 64'h0000_0000_DEAD_BEEF, 3);
      checkOutput("iRdataHold", {32'b0, i_rdata}, lastFetch);
      applyData(1'b0, 64'h100, 64'h0, 1);

      $display("[TB] access timeout");
      memAckEn = 1'b0;
      memQ.push_back('{sel: 1'b0, we: 1'b0, addr: 64'h200, wdata: 64'h0});
      @(posedge clk); #1;
      i_req  = 1'b1;
      i_addr = 64'h200;
      n = 0;
      while (n < 30) begin
         @(negedge clk);
         n++;
         if (err) break;
      end
      checkOutput("errLat", n, 64'd10);
      repeat (3) begin
         @(negedge clk);
         checkOutput("errMreq", {63'b0, m_req}, 64'h0);
         checkOutput("errNoAck", {63'b0, i_ack}, 64'h0);
         checkOutput("errStall", {63'b0, stall}, 64'h1);
         checkOutput("errSticky", {63'b0, err}, 64'h1);
      end
      #2 rst = 1'b1;
      #1 checkOutput("errClear", {63'b0, err}, 64'h0);
      i_req = 1'b0;
      memAckEn = 1'b1;
      resetModels();
      @(negedge clk);
      #2 rst = 1'b0;

      $display("[TB] reset during busy");
      memDelay = 5;
      memQ.push_back('{sel: 1'b0, we: 1'b0, addr: 64'h300, wdata: 64'h0});
      @(posedge clk); #1;
      i_req  = 1'b1;
      i_addr = 64'h300;
      repeat (2) @(negedge clk);
      checkOutput("busyMreq", {63'b0, m_req}, 64'h1);
      #2 rst = 1'b1;
      #1 checkOutput("mReqAsyncDrop", {63'b0, m_req}, 64'h0);
      i_req = 1'b0;
      resetModels();
      @(negedge clk);
      #2 rst = 1'b0;
      applyFetch(64'h300, 1);

      $display("[TB] fetch buffer reuse and store invalidation");
      applyFetch(64'h20, 0);
      applyFetch(64'h20, 0);
      applyData(1'b1, 64'h20, 64'h0123_4567_89AB_CDEF, 0);
      applyFetch(64'h20, 0);

      repeat (3) @(negedge clk);
      checkOutput("memQEmpty", 64'(memQ.size()), 64'h0);
      checkOutput("respQEmpty", 64'(respQ.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
